// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if: psum input and result output handshake bundle
interface psum_accumulator_if #(parameter int ARRAY_SIZE = 8);
  logic psum_valid;
  logic psum_ready;
  logic [ARRAY_SIZE*32-1:0] psums;
  logic out_valid;
  logic out_ready;
  logic [ARRAY_SIZE*32-1:0] out_data;
  modport master(output psum_valid, psums, out_ready, input psum_ready, out_valid, out_data);
  modport slave(input psum_valid, psums, out_ready, output psum_ready, out_valid, out_data);
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums groups of psum vectors per lane, optional relu, queues results in a FIFO
module psum_accumulator #(
  parameter int ARRAY_SIZE = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] acc_len,
  input  logic relu_en,
  psum_accumulator_if.slave bus,
  output logic busy,
  output logic [7:0] beat_cnt
);
  localparam int W = ARRAY_SIZE*32;
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [W-1:0] acc_q, acc_d, sum, result;
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [7:0] len_q, len_d, cnt_q, cnt_d, len_eff;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] fill_q, fill_d;
  logic beat, first, last, push, pop;
  always_comb begin
    bus.psum_ready = fill_q != (PW+1)'(FIFO_DEPTH);
    bus.out_valid = fill_q != '0;
    bus.out_data = bus.out_valid ? mem_q[rd_q] : '0;
    busy = cnt_q != 8'd0;
    beat_cnt = cnt_q;
    beat = bus.psum_valid && bus.psum_ready;
    first = cnt_q == 8'd0;
    // group length is latched on the first beat; later acc_len changes are ignored
    len_eff = first ? (acc_len == 8'd0 ? 8'd1 : acc_len) : len_q;
    last = cnt_q == len_eff - 8'd1;
    push = beat && last;
    pop = bus.out_valid && bus.out_ready;
    sum = '0;
    result = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      sum[32*i +: 32] = first ? bus.psums[32*i +: 32] : acc_q[32*i +: 32] + bus.psums[32*i +: 32];
      result[32*i +: 32] = relu_en && sum[32*i+31] ? 32'h0 : sum[32*i +: 32];
    end
    acc_d = beat ? sum : acc_q;
    len_d = beat && first ? len_eff : len_q;
    cnt_d = beat ? (last ? 8'd0 : cnt_q + 8'd1) : cnt_q;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    fill_d = fill_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      len_q <= 8'd1;
      cnt_q <= 8'd0;
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
    end else begin
      acc_q <= acc_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fill_q <= fill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q] <= result;
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: scoreboard bench for psum_accumulator
module tb_psum_accumulator;
  localparam int N = 8;
  localparam int D = 2;
  localparam int W = N*32;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] acc_len;
  logic relu_en;
  logic busy;
  logic [7:0] beat_cnt;
  psum_accumulator_if #(.ARRAY_SIZE(N)) bus();
  psum_accumulator #(.ARRAY_SIZE(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .acc_len(acc_len), .relu_en(relu_en),
    .bus(bus), .busy(busy), .beat_cnt(beat_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb [$];
  logic [31:0] m_acc [N];
  int m_cnt = 0;
  int m_len = 1;
  bit rand_ready = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_data, mon_exp;
  function automatic logic [W-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1);
    logic [W-1:0] v = '0;
    v[31:0] = l0;
    v[63:32] = l1;
    return v;
  endfunction
  function automatic logic [W-1:0] fill(input logic [31:0] x);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = x;
    return v;
  endfunction
  // scoreboard consumer: every pop is checked in order, stalled heads must hold still
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_stable: out_valid=%b out_data=%h required 1 and %h", bus.out_valid, bus.out_data, prev_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_extra: out_data=%h required no output", bus.out_data);
        end else begin
          mon_exp = sb.pop_front();
          if (bus.out_data !== mon_exp) begin
            failures++;
            $display("FAIL sb_data: out_data=%h required %h", bus.out_data, mon_exp);
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end
  task automatic send(input logic [W-1:0] p, input logic [7:0] len, input logic relu);
    logic rdy;
    logic [W-1:0] r;
    int n = 0;
    bus.psum_valid = 1'b1;
    bus.psums = p;
    acc_len = len;
    relu_en = relu;
    do begin
      @(negedge clk);
      rdy = bus.psum_ready;
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: psum_ready=0 for %0d cycles required acceptance", n);
    end else begin
      if (m_cnt == 0) begin
        m_len = (len == 8'd0) ? 1 : int'(len);
        for (int i = 0; i < N; i++) m_acc[i] = p[32*i +: 32];
      end else
        for (int i = 0; i < N; i++) m_acc[i] = m_acc[i] + p[32*i +: 32];
      if (m_cnt == m_len - 1) begin
        for (int i = 0; i < N; i++) r[32*i +: 32] = (relu && m_acc[i][31]) ? 32'h0 : m_acc[i];
        sb.push_back(r);
        m_cnt = 0;
      end else m_cnt++;
    end
  endtask
  task automatic idle(input int n);
    bus.psum_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.psum_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: psum_ready=%b required 1", bus.psum_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: out_valid=%b required 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data: out_data=%h required 0", bus.out_data); end
    checks++;
    if (busy !== 1'b0 || beat_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: busy=%b beat_cnt=%0d required 0 0", busy, beat_cnt); end
  endtask
  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    send(lanes(32'd5, 32'd1), 8'd3, 1'b0);
    checks++;
    if (busy !== 1'b1 || beat_cnt !== 8'd1) begin failures++; $display("FAIL b2b_beat1: busy=%b beat_cnt=%0d required 1 1", busy, beat_cnt); end
    send(lanes(32'd7, 32'd2), 8'd1, 1'b0);
    checks++;
    if (busy !== 1'b1 || beat_cnt !== 8'd2 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_beat2: busy=%b beat_cnt=%0d out_valid=%b required 1 2 0", busy, beat_cnt, bus.out_valid);
    end
    send(lanes(32'hFFFF_FFFE, 32'd3), 8'd6, 1'b0);
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data[31:0] !== 32'd10) begin
      failures++;
      $display("FAIL b2b_result: busy=%b out_valid=%b lane0=%0d required 0 1 10", busy, bus.out_valid, bus.out_data[31:0]);
    end
    idle(2);
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: pending=%0d out_valid=%b required 0 0", sb.size(), bus.out_valid); end
  endtask
  task automatic test_relu;
    send(lanes(32'hFFFF_FFFC, 32'd9), 8'd1, 1'b1);
    checks++;
    if (bus.out_data[63:0] !== {32'd9, 32'd0}) begin failures++; $display("FAIL relu_len1: lanes1:0=%h required %h", bus.out_data[63:0], {32'd9, 32'd0}); end
    idle(1);
    send(lanes(32'hFFFF_FFFC, 32'd9), 8'd0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data[63:0] !== {32'd9, 32'd0}) begin
      failures++;
      $display("FAIL relu_len0: out_valid=%b lanes1:0=%h required 1 %h", bus.out_valid, bus.out_data[63:0], {32'd9, 32'd0});
    end
    send(lanes(32'hFFFF_FFF6, 32'd3), 8'd2, 1'b0);
    send(lanes(32'd1, 32'd1), 8'd2, 1'b1);
    idle(2);
  endtask
  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    send(lanes(32'd1, 32'd0), 8'd1, 1'b0);
    send(lanes(32'd2, 32'd0), 8'd1, 1'b0);
    checks++;
    if (bus.psum_ready !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_full: psum_ready=%b out_valid=%b required 0 1", bus.psum_ready, bus.out_valid); end
    bus.psum_valid = 1'b1;
    bus.psums = lanes(32'd3, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.psum_ready !== 1'b0 || bus.out_data[31:0] !== 32'd1) begin
        failures++;
        $display("FAIL bp_hold: psum_ready=%b lane0=%0d required 0 1", bus.psum_ready, bus.out_data[31:0]);
      end
    end
    bus.out_ready = 1'b1;
    send(lanes(32'd3, 32'd0), 8'd1, 1'b0);
    idle(4);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL bp_drain: pending=%0d required 0", sb.size()); end
  endtask
  task automatic test_wrap;
    send(lanes(32'h7FFF_FFFF, 32'hFFFF_FFFF), 8'd2, 1'b0);
    send(lanes(32'd1, 32'd1), 8'd2, 1'b0);
    checks++;
    if (bus.out_data[63:0] !== {32'h0, 32'h8000_0000}) begin
      failures++;
      $display("FAIL wrap: lanes1:0=%h required %h", bus.out_data[63:0], {32'h0, 32'h8000_0000});
    end
    idle(2);
  endtask
  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    send(lanes(32'd9, 32'd0), 8'd1, 1'b0);
    send(fill(32'd1), 8'd4, 1'b0);
    send(fill(32'd1), 8'd4, 1'b0);
    checks++;
    if (beat_cnt !== 8'd2 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre: beat_cnt=%0d out_valid=%b required 2 1", beat_cnt, bus.out_valid); end
    bus.psum_valid = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.psum_valid = 1'b0;
    sb.delete();
    m_cnt = 0;
    checks++;
    if (bus.out_valid !== 1'b0 || beat_cnt !== 8'd0 || busy !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL rmid_post: out_valid=%b beat_cnt=%0d busy=%b out_data=%h required 0 0 0 0", bus.out_valid, beat_cnt, busy, bus.out_data);
    end
    repeat (4) send(fill(32'd1), 8'd4, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== fill(32'd4)) begin
      failures++;
      $display("FAIL rmid_sum: out_valid=%b out_data=%h required 1 %h", bus.out_valid, bus.out_data, fill(32'd4));
    end
    idle(2);
  endtask
  task automatic test_random;
    logic [W-1:0] p;
    int len;
    int n = 0;
    rand_ready = 1;
    for (int g = 0; g < 30; g++) begin
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < N; i++) p[32*i +: 32] = $urandom;
        send(p, (b == 0) ? 8'(len) : 8'($urandom), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    rand_ready = 0;
    idle(1);
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rand_drain: pending=%0d out_valid=%b required 0 0", sb.size(), bus.out_valid); end
  endtask
  initial begin
    rst = 1'b1;
    acc_len = 8'd1;
    relu_en = 1'b0;
    bus.psum_valid = 1'b0;
    bus.psums = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_relu();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
